// File: rtl/key_pulse_gen.sv
// key_pulse_gen: conditions four raw active-low push buttons into debounced
// levels and single-cycle press / release / long-press / auto-repeat pulses.
// Optional feature macro: KEY_PULSE_REPEAT_EN (auto-repeat pulses on o_rpt);
// when undefined o_rpt is tied low and the HELD hold counter stays frozen.
module key_pulse_gen #(
    parameter int unsigned SAMPLE_DIV = 500000,
    parameter int unsigned STABLE_N   = 3,
    parameter int unsigned LONG_N     = 100,
    parameter int unsigned REPEAT_N   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_sw,
    output logic [3:0] o_level,
    output logic [3:0] o_press,
    output logic [3:0] o_release,
    output logic [3:0] o_long,
    output logic [3:0] o_rpt
);

    localparam int unsigned NKEY   = 4;
    localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned STAB_W = 4;
    localparam int unsigned HOLD_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } key_state_e;

    // Elaboration-time guard on the legal parameter ranges.
    if (SAMPLE_DIV < 2 || STABLE_N < 1 || STABLE_N > 15 ||
        LONG_N < 2 || LONG_N > 1023 || REPEAT_N < 1 || REPEAT_N > 1023) begin : g_param_err
        $error("key_pulse_gen: parameter out of range");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_c;
    logic [NKEY-1:0]  sync1_q, sync2_q;

    assign tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));

    // Shared sample-tick divider, wraps at SAMPLE_DIV-1.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (tick_c) begin
            div_d = '0;
        end
    end

    // Tick counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Two-flop synchronizer; inverts so that 1 means pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~i_sw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < NKEY; k++) begin : g_key
        logic [STAB_W-1:0] stab_q, stab_d;
        logic              level_q, level_d;
        logic              rise_c, fall_c;
        key_state_e        state_q;
        logic [HOLD_W-1:0] hold_q;
        logic              press_q, release_q, long_q;
`ifdef KEY_PULSE_REPEAT_EN
        logic              rpt_q;
`endif

        // Debounce: level flips after STABLE_N consecutive disagreeing ticks.
        always_comb begin
            stab_d  = stab_q;
            level_d = level_q;
            if (tick_c) begin
                if (sync2_q[k] == level_q) begin
                    stab_d = '0;
                end else if (stab_q + STAB_W'(1) == STAB_W'(STABLE_N)) begin
                    stab_d  = '0;
                    level_d = ~level_q;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
        end

        assign rise_c = level_d & ~level_q;
        assign fall_c = ~level_d & level_q;

        // Event FSM; a level change always takes priority over hold-count events.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stab_q    <= '0;
                level_q   <= 1'b0;
                state_q   <= ST_IDLE;
                hold_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
`ifdef KEY_PULSE_REPEAT_EN
                rpt_q     <= 1'b0;
`endif
            end else begin
                stab_q    <= stab_d;
                level_q   <= level_d;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
`ifdef KEY_PULSE_REPEAT_EN
                rpt_q     <= 1'b0;
`endif
                if (rise_c) begin
                    state_q <= ST_PRESSED;
                    hold_q  <= '0;
                    press_q <= 1'b1;
                end else if (fall_c) begin
                    state_q   <= ST_IDLE;
                    hold_q    <= '0;
                    release_q <= 1'b1;
                end else if (tick_c) begin
                    case (state_q)
                        ST_PRESSED: begin
                            if (hold_q + HOLD_W'(1) == HOLD_W'(LONG_N)) begin
                                long_q  <= 1'b1;
                                hold_q  <= '0;
                                state_q <= ST_HELD;
                            end else begin
                                hold_q <= hold_q + HOLD_W'(1);
                            end
                        end
                        ST_HELD: begin
`ifdef KEY_PULSE_REPEAT_EN
                            if (hold_q + HOLD_W'(1) == HOLD_W'(REPEAT_N)) begin
                                rpt_q  <= 1'b1;
                                hold_q <= '0;
                            end else begin
                                hold_q <= hold_q + HOLD_W'(1);
                            end
`endif
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end

        assign o_level[k]   = level_q;
        assign o_press[k]   = press_q;
        assign o_release[k] = release_q;
        assign o_long[k]    = long_q;
`ifdef KEY_PULSE_REPEAT_EN
        assign o_rpt[k]     = rpt_q;
`endif
    end

`ifndef KEY_PULSE_REPEAT_EN
    assign o_rpt = '0;
`endif

endmodule
